// File: rtl/output_writeback.sv
// Output write-back stage: buffers per-layer results (activation or pooling
// path) in a small FIFO and streams them to the output memory at
// consecutive addresses, with ready/valid style backpressure from memory.
module output_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  layer_signal,
  input  logic [ADDR_WIDTH-1:0] layer_len,
  input  logic [ADDR_WIDTH-1:0] base_addr_fc,
  input  logic [ADDR_WIDTH-1:0] base_addr_pool,
  input  logic                  write_signal,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic [DATA_WIDTH-1:0] pool_data,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  fifo_full,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  overflow
);

  // Pointer width; FIFO_DEPTH is a power of two so pointers wrap naturally.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Occupancy needs one extra bit to represent "completely full".
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nx;

  // Per-layer context captured when a start is accepted.
  logic                   sel;
  logic [ADDR_WIDTH-1:0]  len;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  push_cnt;

  // Result buffer.
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   fifo_empty;
  logic                   full_int;
  logic                   accept_start;
  logic                   push_req;
  logic                   push_ok;
  logic                   drop;
  logic                   pop;
  logic                   last_push;
  logic [DATA_WIDTH-1:0]  push_data;

  assign fifo_empty   = (count == '0);
  assign full_int     = (count == CNT_W'(FIFO_DEPTH));

  // A start is only honoured from IDLE; anywhere else it is ignored.
  assign accept_start = (state == S_IDLE) && start;

  // Every write_signal in RUN counts toward the layer length, accepted or not.
  // A full buffer rejects the push even if a pop frees a slot this cycle,
  // which keeps the full flag purely register-based.
  assign push_req     = (state == S_RUN) && write_signal;
  assign push_ok      = push_req && !full_int;
  assign drop         = push_req && full_int;
  assign push_data    = sel ? pool_data : act_data;
  assign last_push    = push_req && ((push_cnt + 1'b1) == len);

  // Memory-side handshake; all outputs derive from registers only.
  assign mem_we       = ((state == S_RUN) || (state == S_DRAIN)) && !fifo_empty;
  assign pop          = mem_we && mem_ready;
  assign mem_addr     = addr;
  // An empty buffer presents zero, so stale storage never reaches the bus
  // (in particular during and right after reset).
  assign mem_wdata    = fifo_empty ? '0 : fifo_mem[rd_ptr];

  assign fifo_full    = full_int;
  assign busy         = (state != S_IDLE);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode for the layer sequence IDLE -> RUN -> DRAIN -> DONE.
  // NOTE: state_nx is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (layer_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_push) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Layer context, address generator, push counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 1'b0;
      len        <= '0;
      addr       <= '0;
      push_cnt   <= '0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      // Registered pulse: asserted the cycle after the DONE state.
      layer_done <= (state == S_DONE);
      if (accept_start) begin
        sel      <= layer_signal;
        len      <= layer_len;
        addr     <= layer_signal ? base_addr_pool : base_addr_fc;
        push_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_req) begin
          push_cnt <= push_cnt + 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
        // Address advances only on a completed transfer and wraps modulo
        // the address space.
        if (pop) begin
          addr <= addr + 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers/count, and the read side is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: a queue-based reference model
// checked every cycle, plus literal expectations for each directed scenario.
module tb_output_writeback;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          layer_signal = 1'b0;
  logic [AW-1:0] layer_len = '0;
  logic [AW-1:0] base_addr_fc = '0;
  logic [AW-1:0] base_addr_pool = '0;
  logic          write_signal = 1'b0;
  logic [DW-1:0] act_data = '0;
  logic [DW-1:0] pool_data = '0;
  logic          mem_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          fifo_full;
  logic          busy;
  logic          layer_done;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  output_writeback #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .layer_signal  (layer_signal),
    .layer_len     (layer_len),
    .base_addr_fc  (base_addr_fc),
    .base_addr_pool(base_addr_pool),
    .write_signal  (write_signal),
    .act_data      (act_data),
    .pool_data     (pool_data),
    .mem_ready     (mem_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .layer_done    (layer_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 collecting, 2 draining, 3 finishing
  int            m_phase = 0;
  logic [DW-1:0] m_q[$];
  logic [AW-1:0] m_addr = '0;
  logic          m_sel = 1'b0;
  int            m_len = 0;
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_ld = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int   pre;
    logic pop;
    if (!rst_n) begin
      m_phase = 0;
      m_q.delete();
      m_addr  = '0;
      m_sel   = 1'b0;
      m_len   = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_ld    = 1'b0;
    end else begin
      pre  = m_q.size();
      pop  = (m_phase == 1 || m_phase == 2) && pre != 0 && mem_ready;
      m_ld = (m_phase == 3);
      if (pop) begin
        m_q.delete(0);
        m_addr = m_addr + 1'b1;
      end
      case (m_phase)
        0: if (start) begin
          m_sel   = layer_signal;
          m_len   = int'(layer_len);
          m_addr  = layer_signal ? base_addr_pool : base_addr_fc;
          m_cnt   = 0;
          m_ovf   = 1'b0;
          m_phase = (layer_len == '0) ? 3 : 1;
        end
        1: if (write_signal) begin
          if (pre < DEPTH) m_q.push_back(m_sel ? pool_data : act_data);
          else m_ovf = 1'b1;
          m_cnt++;
          if (m_cnt == m_len) m_phase = 2;
        end
        2: if (pre == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic exp_we;
    if (!rst_n) begin
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fifo_full", 32'(fifo_full), 32'd0);
      check("rst_layer_done", 32'(layer_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
    end else begin
      exp_we = (m_phase == 1 || m_phase == 2) && m_q.size() != 0;
      check("cyc_mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        check("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
        check("cyc_mem_wdata", 32'(mem_wdata), 32'(m_q[0]));
      end
      check("cyc_fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
      check("cyc_busy", 32'(busy), 32'(m_phase != 0));
      check("cyc_layer_done", 32'(layer_done), 32'(m_ld));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- transfer log ----------------
  logic [AW+DW-1:0] log_q[$];
  logic [AW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) log_q.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic ls, input int len);
    start        = 1'b1;
    layer_signal = ls;
    layer_len    = AW'(len);
    tick();
    start        = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] p);
    write_signal = 1'b1;
    act_data     = a;
    pool_data    = p;
    tick();
    write_signal = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (layer_done) found = 1'b1;
    end
    check({name, "_done_seen"}, 32'(found), 32'd1);
    tick();
  endtask

  task automatic expect_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string name);
    check({name, "_nwrites"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_write%0d", name, i), 32'(log_q[i]), 32'(exp_q[i]));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Basic FC layer.
    base_addr_fc = 12'h100;
    mem_ready    = 1'b1;
    start_layer(1'b0, 4);
    for (int d = 1; d <= 4; d++) push(DW'(d), 16'h0);
    wait_done("fc", 40);
    for (int d = 0; d < 4; d++) expect_w(12'h100 + AW'(d), DW'(d + 1));
    check_writes("fc");

    // write_signal while idle is ignored, then pooling select.
    write_signal = 1'b1;
    act_data     = 16'h77;
    tick();
    tick();
    write_signal = 1'b0;
    check("lit_idle_ws_overflow", 32'(overflow), 32'd0);
    check("lit_idle_ws_busy", 32'(busy), 32'd0);
    base_addr_pool = 12'h200;
    start_layer(1'b1, 2);
    push(16'h11, 16'hAA);
    push(16'h11, 16'hBB);
    wait_done("pool", 40);
    expect_w(12'h200, 16'hAA);
    expect_w(12'h201, 16'hBB);
    check_writes("pool");

    // Backpressure and overflow.
    base_addr_fc = 12'h300;
    mem_ready    = 1'b0;
    start_layer(1'b0, 10);
    for (int d = 1; d <= 10; d++) push(DW'(d), 16'h0);
    check("lit_ovf_full", 32'(fifo_full), 32'd1);
    check("lit_ovf_flag", 32'(overflow), 32'd1);
    mem_ready = 1'b1;
    wait_done("ovf", 60);
    for (int d = 0; d < 8; d++) expect_w(12'h300 + AW'(d), DW'(d + 1));
    check_writes("ovf");
    check("lit_ovf_sticky", 32'(overflow), 32'd1);

    // Stall during continuous pushes; a stray start mid-layer is ignored.
    base_addr_fc = 12'h040;
    start_layer(1'b0, 6);
    check("lit_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i % 2 == 0);
      if (i == 2) begin
        start        = 1'b1;
        layer_signal = 1'b1;
      end
      push(16'h21 + DW'(i), 16'h99);
      start = 1'b0;
    end
    mem_ready = 1'b1;
    wait_done("stall", 60);
    for (int i = 0; i < 6; i++) expect_w(12'h040 + AW'(i), 16'h21 + DW'(i));
    check_writes("stall");

    // Zero-length layer: layer_done two cycles after start, no writes.
    start_layer(1'b0, 0);
    @(negedge clk);
    check("lit_len0_early", 32'(layer_done), 32'd0);
    @(negedge clk);
    check("lit_len0_pulse", 32'(layer_done), 32'd1);
    tick();
    check_writes("len0");

    // Address wrap.
    base_addr_fc = 12'hFFE;
    start_layer(1'b0, 3);
    push(16'h51, 16'h0);
    push(16'h52, 16'h0);
    push(16'h53, 16'h0);
    wait_done("wrap", 40);
    expect_w(12'hFFE, 16'h51);
    expect_w(12'hFFF, 16'h52);
    expect_w(12'h000, 16'h53);
    check_writes("wrap");

    // Reset mid-layer with three words buffered.
    base_addr_fc = 12'h500;
    mem_ready    = 1'b0;
    start_layer(1'b0, 5);
    push(16'h61, 16'h0);
    push(16'h62, 16'h0);
    push(16'h63, 16'h0);
    check("lit_pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("lit_midrst_we", 32'(mem_we), 32'd0);
    check("lit_midrst_busy", 32'(busy), 32'd0);
    check("lit_midrst_addr", 32'(mem_addr), 32'd0);
    check("lit_midrst_wdata", 32'(mem_wdata), 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check_writes("midrst");
    base_addr_fc = 12'h600;
    start_layer(1'b0, 2);
    push(16'h71, 16'h0);
    push(16'h72, 16'h0);
    wait_done("post_rst", 40);
    expect_w(12'h600, 16'h71);
    expect_w(12'h601, 16'h72);
    check_writes("post_rst");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
